uop_queue: RTL and testbench
============================

// Module: uop_queue
//
// PURPOSE
//   Decoupling FIFO between the ucode stage (uc0) and rename (rn0).
//   Accepts one t_uinstr per cycle from ucode. Presents the oldest uop to rename.
//   Drives rename_ready_rn0 back to ucode/decode as the backpressure signal.
//   Drops all buffered uops on a retire-stage nuke.
//
// PARAMETERS
//   DEPTH   4   number of uop entries; power of 2, >= 2
//
// PORTS
//   clk               in   1         clock
//   reset             in   1         synchronous, active-high reset
//   nuke_rb1          in   t_nuke_pkt  flush request; only .valid is used here
//   valid_uc0         in   1         ucode presents a uop this cycle
//   uinstr_uc0        in   t_uinstr  uop from ucode
//   rename_ready_rn0  out  1         queue can accept a uop this cycle
//   valid_rn0         out  1         uop available to rename
//   uinstr_rn0        out  t_uinstr  oldest uop (head)
//   rename_accept_rn0 in   1         rename consumes head this cycle
//   occupancy_rn0     out  $clog2(DEPTH)+1  current entry count
//
// BEHAVIOUR
//   - State
//     - Storage: DEPTH x t_uinstr entries.
//     - wr_ptr, rd_ptr: $clog2(DEPTH) bits each, wrap modulo DEPTH.
//     - count: $clog2(DEPTH)+1 bits.
//   - Reset (reset=1)
//     - wr_ptr, rd_ptr and count go to 0 on the next edge.
//     - While reset is high: rename_ready_rn0=0, valid_rn0=0, occupancy_rn0=0.
//     - Entry data is not reset; uinstr_rn0 is don't-care whenever valid_rn0=0.
//   - Ready
//     - rename_ready_rn0 = ~reset & (count != DEPTH).
//     - Depends only on flops (no combinational path from rename_accept_rn0).
//     - When full, there is no pass-through: ready stays 0 even if rename dequeues that cycle.
//   - Enqueue
//     - enq = valid_uc0 & rename_ready_rn0 & ~nuke_rb1.valid.
//     - On enq: write entry[wr_ptr]; wr_ptr++ (wraps from DEPTH-1 to 0).
//   - Dequeue
//     - deq = valid_rn0 & rename_accept_rn0 & ~nuke_rb1.valid.
//     - On deq: rd_ptr++ (wraps).
//     - rename_accept_rn0 while valid_rn0=0 has no effect.
//   - Count
//     - count_nxt = count + enq - deq.
//     - Simultaneous enq and deq at a non-full count leaves count unchanged.
//   - Output
//     - valid_rn0 = ~reset & (count != 0); uinstr_rn0 = entry[rd_ptr].
//     - Latency: a uop enqueued at edge N is visible at rn0 in cycle N+1 (default build).
//   - Ordering: strict FIFO; uops are never reordered or duplicated.
//   - Nuke (nuke_rb1.valid=1)
//     - The same-cycle enqueue and dequeue are suppressed.
//     - wr_ptr, rd_ptr and count go to 0 at the next edge.
//     - valid_rn0 is still driven in the nuke cycle, but no deq is counted.
//     - Priority: reset > nuke > enq/deq.
//   - occupancy_rn0 = count.
//   - SIMULATION only: `UINFO(uinstr_rn0.SIMID, "unit:UQ func:deq") on each deq.
//   - ASSERT checks:
//     - count <= DEPTH.
//     - No enq while count==DEPTH.
//     - No deq while count==0 (bypass path excluded).
//
// CONFIGURATION
//   UOPQ_BYPASS_EN defined
//     - When count==0 and valid_uc0 & rename_ready_rn0 & ~nuke_rb1.valid:
//       valid_rn0=1 and uinstr_rn0=uinstr_uc0 in the same cycle (0-cycle latency).
//     - If rename_accept_rn0=1 in that cycle: nothing is written; pointers and count are unchanged.
//     - Otherwise: the uop is enqueued as normal.
//     - Bypass never applies when count>0, so ordering is preserved.
//   UOPQ_BYPASS_EN undefined
//     - No bypass; minimum latency is 1 cycle as described above.
//
// TESTING
//   1. Reset 3 cycles, then idle.
//      -> valid_rn0=0, rename_ready_rn0=1 from first post-reset cycle, occupancy_rn0=0.
//   2. Fill: 4 uops A..D enqueued with rename_accept_rn0=0, DEPTH=4.
//      -> occupancy 1,2,3,4; rename_ready_rn0=0 after D.
//      -> a 5th valid_uc0 is not accepted; head stays A.
//   3. Drain while full: accept=1 for 4 cycles.
//      -> rn0 sees A,B,C,D in order; ready returns to 1 the cycle after A's deq.
//      -> occupancy ends at 0.
//   4. Wrap: 10 back-to-back uops with accept=1 every cycle (non-bypass build).
//      -> occupancy holds at 1, pointers wrap past 3, output order matches input order.
//   5. Nuke with occupancy 3 while valid_uc0=1 and accept=1.
//      -> next cycle occupancy_rn0=0, valid_rn0=0.
//      -> the incoming uop is dropped; no deq is logged.
//   6. UOPQ_BYPASS_EN, empty queue, valid_uc0=1 with uop X, accept=1.
//      -> valid_rn0=1, uinstr_rn0=X in the same cycle; occupancy stays 0.
//      -> Repeat with accept=0: occupancy becomes 1 and X is head next cycle.

Source files
------------

// File: rtl/uop_queue_if.sv
// uop_queue_if: shared types and the ucode/rename handshake bundle for uop_queue.
// The package holds the uop and nuke packet types used on both sides of the queue.
// Modport slave is the queue's view; modport master is the ucode/rename/retire side.

package uop_queue_pkg;
    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] simid;
    } t_uinstr;

    typedef struct packed {
        logic valid;
    } t_nuke_pkt;
endpackage

interface uop_queue_if #(parameter int DEPTH = 4);
    import uop_queue_pkg::*;

    t_nuke_pkt                    nuke_rb1;
    logic                         valid_uc0;
    t_uinstr                      uinstr_uc0;
    logic                         rename_ready_rn0;
    logic                         valid_rn0;
    t_uinstr                      uinstr_rn0;
    logic                         rename_accept_rn0;
    logic [$clog2(DEPTH):0]       occupancy_rn0;

    modport slave (
        input  nuke_rb1,
        input  valid_uc0,
        input  uinstr_uc0,
        input  rename_accept_rn0,
        output rename_ready_rn0,
        output valid_rn0,
        output uinstr_rn0,
        output occupancy_rn0
    );

    modport master (
        output nuke_rb1,
        output valid_uc0,
        output uinstr_uc0,
        output rename_accept_rn0,
        input  rename_ready_rn0,
        input  valid_rn0,
        input  uinstr_rn0,
        input  occupancy_rn0
    );
endinterface

// File: rtl/uop_queue.sv
// uop_queue: decoupling FIFO between ucode (uc0) and rename (rn0).
// Ready is derived from flops only, so a full queue never passes through a
// same-cycle dequeue. A retire nuke empties the queue at the next edge.
// Optional feature: define UOPQ_BYPASS_EN to forward a uop arriving at an empty
// queue straight to rename in the same cycle.

module uop_queue_chk #(parameter int DEPTH = 4) (
    input logic                   clk,
    input logic                   reset,
    input logic [$clog2(DEPTH):0] count_i,
    input logic                   enq_i,
    input logic                   deq_i
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    a_count_bound: assert property (@(posedge clk) disable iff (reset) count_i <= FULL_CNT);
    a_no_enq_full: assert property (@(posedge clk) disable iff (reset) !(enq_i && (count_i == FULL_CNT)));
    a_no_deq_empty: assert property (@(posedge clk) disable iff (reset) !(deq_i && (count_i == {CNT_W{1'b0}})));
endmodule

module uop_queue
    import uop_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic       clk,
    input logic       reset,
    uop_queue_if.slave uq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    t_uinstr          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic ready_s;
    logic nonempty_s;
    logic nuke_s;
    logic offer_s;
    logic bypass_s;
    logic enq_s;
    logic deq_s;

    // Handshake qualification: ready/valid come from flops, nuke kills enq and deq.
    always_comb begin
        nuke_s     = uq.nuke_rb1.valid;
        ready_s    = ~reset & (count_q != FULL_CNT);
        nonempty_s = ~reset & (count_q != {CNT_W{1'b0}});
        offer_s    = uq.valid_uc0 & ready_s & ~nuke_s;
        deq_s      = nonempty_s & uq.rename_accept_rn0 & ~nuke_s;
`ifdef UOPQ_BYPASS_EN
        // An empty queue forwards the incoming uop; if rename takes it, nothing is stored.
        bypass_s   = offer_s & (count_q == {CNT_W{1'b0}});
        enq_s      = offer_s & ~(bypass_s & uq.rename_accept_rn0);
`else
        bypass_s   = 1'b0;
        enq_s      = offer_s;
`endif
    end

    assign uq.rename_ready_rn0 = ready_s;
    assign uq.valid_rn0        = nonempty_s | bypass_s;
    assign uq.uinstr_rn0       = bypass_s ? uq.uinstr_uc0 : mem_q[rd_ptr_q];
    assign uq.occupancy_rn0    = reset ? {CNT_W{1'b0}} : count_q;

    // Next-state for pointers and count; reset beats nuke beats enq/deq.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (reset || nuke_s) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(enq_s) - CNT_W'(deq_s);
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // Entry storage; data is intentionally not reset.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_q[wr_ptr_q] <= uq.uinstr_uc0;
        end
    end

    uop_queue_chk #(.DEPTH(DEPTH)) u_chk (
        .clk     (clk),
        .reset   (reset),
        .count_i (count_q),
        .enq_i   (enq_s),
        .deq_i   (deq_s)
    );
endmodule

// File: tb/tb_uop_queue.sv
// tb_uop_queue: directed self-checking bench for uop_queue (DEPTH=4).
// Build with +define+UOPQ_BYPASS_EN to exercise the same-cycle forwarding path.

module tb_uop_queue;
    import uop_queue_pkg::*;

    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;

    uop_queue_if #(.DEPTH(4)) uq_if ();

    uop_queue #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .uq    (uq_if.slave)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic t_uinstr mk_uop(input logic [7:0] op, input logic [15:0] id);
        t_uinstr u;
        u.opcode = op;
        u.simid  = id;
        return u;
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        reset   = 1'b1;
        uq_if.nuke_rb1          = '0;
        uq_if.valid_uc0         = 1'b0;
        uq_if.uinstr_uc0        = '0;
        uq_if.rename_accept_rn0 = 1'b0;

        // 1. Reset for 3 cycles, outputs forced low.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_val("rst_ready", 32'(uq_if.rename_ready_rn0), 32'd0);
            chk_val("rst_valid", 32'(uq_if.valid_rn0), 32'd0);
            chk_val("rst_occ", 32'(uq_if.occupancy_rn0), 32'd0);
        end
        reset = 1'b0;
        #1;
        chk_val("post_rst_ready", 32'(uq_if.rename_ready_rn0), 32'd1);
        chk_val("post_rst_valid", 32'(uq_if.valid_rn0), 32'd0);
        chk_val("post_rst_occ", 32'(uq_if.occupancy_rn0), 32'd0);
        tick();

        // 2. Fill with A..D, no accept.
        for (int i = 0; i < 4; i++) begin
            uq_if.valid_uc0  = 1'b1;
            uq_if.uinstr_uc0 = mk_uop(8'hA0 + 8'(i), 16'(i));
            tick();
            chk_val("fill_occ", 32'(uq_if.occupancy_rn0), 32'(i + 1));
        end
        chk_val("full_ready", 32'(uq_if.rename_ready_rn0), 32'd0);
        uq_if.uinstr_uc0 = mk_uop(8'hAE, 16'h00EE);
        tick();
        chk_val("full_occ", 32'(uq_if.occupancy_rn0), 32'd4);
        chk_val("full_head", 32'(uq_if.uinstr_rn0), 32'(mk_uop(8'hA0, 16'd0)));
        chk_val("full_valid", 32'(uq_if.valid_rn0), 32'd1);

        // 3. Drain while full.
        uq_if.valid_uc0         = 1'b0;
        uq_if.rename_accept_rn0 = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_val("drain_valid", 32'(uq_if.valid_rn0), 32'd1);
            chk_val("drain_head", 32'(uq_if.uinstr_rn0), 32'(mk_uop(8'hA0 + 8'(i), 16'(i))));
            if (i == 0) chk_val("drain_ready_before", 32'(uq_if.rename_ready_rn0), 32'd0);
            tick();
            if (i == 0) chk_val("drain_ready_after", 32'(uq_if.rename_ready_rn0), 32'd1);
        end
        chk_val("drain_occ", 32'(uq_if.occupancy_rn0), 32'd0);
        chk_val("drain_empty_valid", 32'(uq_if.valid_rn0), 32'd0);

`ifndef UOPQ_BYPASS_EN
        // 4. Back-to-back stream of 10 with accept every cycle; pointers wrap.
        uq_if.valid_uc0 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            uq_if.uinstr_uc0 = mk_uop(8'h40 + 8'(k), 16'h0100 + 16'(k));
            #1;
            if (k == 0) begin
                chk_val("wrap_first_valid", 32'(uq_if.valid_rn0), 32'd0);
            end else begin
                chk_val("wrap_head", 32'(uq_if.uinstr_rn0), 32'(mk_uop(8'h40 + 8'(k - 1), 16'h0100 + 16'(k - 1))));
            end
            tick();
            chk_val("wrap_occ", 32'(uq_if.occupancy_rn0), 32'd1);
        end
        uq_if.valid_uc0 = 1'b0;
        #1;
        chk_val("wrap_last", 32'(uq_if.uinstr_rn0), 32'(mk_uop(8'h49, 16'h0109)));
        tick();
        chk_val("wrap_end_occ", 32'(uq_if.occupancy_rn0), 32'd0);
`endif

        // 5. Nuke with occupancy 3 while enq and accept are both asserted.
        uq_if.rename_accept_rn0 = 1'b0;
        uq_if.valid_uc0         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            uq_if.uinstr_uc0 = mk_uop(8'h60 + 8'(i), 16'h0200 + 16'(i));
            tick();
        end
        chk_val("nuke_pre_occ", 32'(uq_if.occupancy_rn0), 32'd3);
        uq_if.uinstr_uc0        = mk_uop(8'h6F, 16'h02FF);
        uq_if.rename_accept_rn0 = 1'b1;
        uq_if.nuke_rb1.valid    = 1'b1;
        #1;
        chk_val("nuke_cycle_valid", 32'(uq_if.valid_rn0), 32'd1);
        chk_val("nuke_cycle_head", 32'(uq_if.uinstr_rn0), 32'(mk_uop(8'h60, 16'h0200)));
        tick();
        uq_if.nuke_rb1.valid    = 1'b0;
        uq_if.valid_uc0         = 1'b0;
        uq_if.rename_accept_rn0 = 1'b0;
        #1;
        chk_val("nuke_occ", 32'(uq_if.occupancy_rn0), 32'd0);
        chk_val("nuke_valid", 32'(uq_if.valid_rn0), 32'd0);
        uq_if.valid_uc0  = 1'b1;
        uq_if.uinstr_uc0 = mk_uop(8'h70, 16'h0300);
        tick();
        uq_if.valid_uc0 = 1'b0;
        #1;
        chk_val("post_nuke_occ", 32'(uq_if.occupancy_rn0), 32'd1);
        chk_val("post_nuke_head", 32'(uq_if.uinstr_rn0), 32'(mk_uop(8'h70, 16'h0300)));
        uq_if.rename_accept_rn0 = 1'b1;
        tick();
        uq_if.rename_accept_rn0 = 1'b0;
        #1;
        chk_val("post_nuke_drain", 32'(uq_if.occupancy_rn0), 32'd0);

`ifdef UOPQ_BYPASS_EN
        // 6. Bypass into an empty queue, first taken, then held.
        uq_if.valid_uc0         = 1'b1;
        uq_if.uinstr_uc0        = mk_uop(8'h88, 16'h0400);
        uq_if.rename_accept_rn0 = 1'b1;
        #1;
        chk_val("byp_valid", 32'(uq_if.valid_rn0), 32'd1);
        chk_val("byp_head", 32'(uq_if.uinstr_rn0), 32'(mk_uop(8'h88, 16'h0400)));
        tick();
        chk_val("byp_occ", 32'(uq_if.occupancy_rn0), 32'd0);
        uq_if.rename_accept_rn0 = 1'b0;
        #1;
        chk_val("byp_hold_valid", 32'(uq_if.valid_rn0), 32'd1);
        tick();
        uq_if.valid_uc0 = 1'b0;
        #1;
        chk_val("byp_hold_occ", 32'(uq_if.occupancy_rn0), 32'd1);
        chk_val("byp_hold_head", 32'(uq_if.uinstr_rn0), 32'(mk_uop(8'h88, 16'h0400)));
        uq_if.rename_accept_rn0 = 1'b1;
        tick();
        uq_if.rename_accept_rn0 = 1'b0;
        #1;
        chk_val("byp_end_occ", 32'(uq_if.occupancy_rn0), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
